// File: rtl/fft_output_reorder_if.sv
// Stream bundle for fft_output_reorder: FFT-order input beats in, natural-order beats out.
// The peak_* signals exist only when FFT_REORDER_PEAK_EN is defined.
interface fft_output_reorder_if #(
    parameter int WIDTH       = 32,
    parameter int NUM_SAMPLES = 16,
    parameter int LANES       = 4
);
    localparam int AW = $clog2(NUM_SAMPLES);

    logic                     in_en;
    logic                     in_ready;
    logic [LANES*WIDTH-1:0]   in_real;
    logic [LANES*WIDTH-1:0]   in_imag;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*WIDTH-1:0]   out_real;
    logic [LANES*WIDTH-1:0]   out_imag;
    logic [AW-1:0]            out_base;
    logic                     out_last;
`ifdef FFT_REORDER_PEAK_EN
    logic [AW-1:0]            peak_index;
    logic [WIDTH:0]           peak_mag;
    logic                     peak_valid;
`endif

    // master: the side that feeds FFT beats and consumes reordered beats
    modport master (
        output in_en, in_real, in_imag, out_ready,
`ifdef FFT_REORDER_PEAK_EN
        input  peak_index, peak_mag, peak_valid,
`endif
        input  in_ready, out_valid, out_real, out_imag, out_base, out_last
    );

    // slave: the reorder buffer itself
    modport slave (
        input  in_en, in_real, in_imag, out_ready,
`ifdef FFT_REORDER_PEAK_EN
        output peak_index, peak_mag, peak_valid,
`endif
        output in_ready, out_valid, out_real, out_imag, out_base, out_last
    );
endinterface

// File: rtl/fft_output_reorder.sv
// Ping-pong reorder buffer: FFT-native beat order in, natural bin order out, valid/ready both sides.
// Optional frame peak detector (max |re|+|im|) enabled by defining FFT_REORDER_PEAK_EN.
module fft_output_reorder #(
    parameter int WIDTH       = 32,
    parameter int NUM_SAMPLES = 16,
    parameter int LANES       = 4,
    parameter int INPUT_ORDER = 0
) (
    input logic                 clock,
    input logic                 reset,
    fft_output_reorder_if.slave bus
);
    localparam int AW     = $clog2(NUM_SAMPLES);
    localparam int BEATS  = NUM_SAMPLES / LANES;
    localparam int CW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int DIGITS = AW / 2;

    typedef logic signed [WIDTH-1:0] sample_t;

    sample_t                mem_re [2*NUM_SAMPLES];
    sample_t                mem_im [2*NUM_SAMPLES];

    logic [1:0]             full;
    logic [1:0]             full_next;
    logic                   wr_bank;
    logic                   rd_bank;
    logic [CW-1:0]          wr_cnt;
    logic [CW-1:0]          rd_cnt;

    logic                   accept;
    logic                   wr_done;
    logic                   load;
    logic                   rd_done;

    logic                   vld_p0;
    logic [LANES*WIDTH-1:0] re_p0;
    logic [LANES*WIDTH-1:0] im_p0;
    logic [AW-1:0]          base_p0;
    logic                   last_p0;

    // Bank address of lane k within input beat c, following the FFT's native output order.
    function automatic logic [AW-1:0] wr_addr(input logic [CW-1:0] c, input int k);
        logic [AW-1:0] lin;
        logic [AW-1:0] rev;
        lin = '0;
        rev = '0;
        if (INPUT_ORDER == 1) begin
            lin = AW'(int'(c) * LANES + k);
            for (int d = 0; d < DIGITS; d++) begin
                rev[2*d +: 2] = lin[AW-2-2*d +: 2];
            end
        end else begin
            rev = AW'(int'(c) + k * BEATS);
        end
        return rev;
    endfunction

    function automatic logic [AW-1:0] rd_addr(input logic [CW-1:0] r, input int k);
        return AW'(int'(r) * LANES + k);
    endfunction

    assign bus.in_ready = !full[wr_bank];
    assign accept       = bus.in_en && !full[wr_bank];
    assign wr_done      = accept && (wr_cnt == CW'(BEATS - 1));

    // A bank is released as soon as its last beat sits in the output register, so a
    // continuous 1 beat/cycle stream never sees in_ready drop.
    assign load         = full[rd_bank] && (!vld_p0 || bus.out_ready);
    assign rd_done      = load && (rd_cnt == CW'(BEATS - 1));

    always_comb begin
        full_next = full;
        if (wr_done) full_next[wr_bank] = 1'b1;
        if (rd_done) full_next[rd_bank] = 1'b0;
    end

    // Input stage: scatter one beat into the write bank
    always_ff @(posedge clock) begin
        if (accept) begin
            for (int k = 0; k < LANES; k++) begin
                mem_re[{wr_bank, wr_addr(wr_cnt, k)}] <= $signed(bus.in_real[k*WIDTH +: WIDTH]);
                mem_im[{wr_bank, wr_addr(wr_cnt, k)}] <= $signed(bus.in_imag[k*WIDTH +: WIDTH]);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
        end else begin
            full <= full_next;
            if (accept) wr_cnt <= wr_done ? '0 : wr_cnt + CW'(1);
            if (wr_done) wr_bank <= ~wr_bank;
            if (load) rd_cnt <= rd_done ? '0 : rd_cnt + CW'(1);
            if (rd_done) rd_bank <= ~rd_bank;
        end
    end

    // Output stage p0: LANES consecutive bins gathered from the read bank
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p0  <= 1'b0;
            re_p0   <= '0;
            im_p0   <= '0;
            base_p0 <= '0;
            last_p0 <= 1'b0;
        end else if (load) begin
            vld_p0  <= 1'b1;
            for (int k = 0; k < LANES; k++) begin
                re_p0[k*WIDTH +: WIDTH] <= mem_re[{rd_bank, rd_addr(rd_cnt, k)}];
                im_p0[k*WIDTH +: WIDTH] <= mem_im[{rd_bank, rd_addr(rd_cnt, k)}];
            end
            base_p0 <= AW'(int'(rd_cnt) * LANES);
            last_p0 <= (rd_cnt == CW'(BEATS - 1));
        end else if (bus.out_ready) begin
            vld_p0  <= 1'b0;
        end
    end

    assign bus.out_valid = vld_p0;
    assign bus.out_real  = re_p0;
    assign bus.out_imag  = im_p0;
    assign bus.out_base  = base_p0;
    assign bus.out_last  = last_p0;

`ifdef FFT_REORDER_PEAK_EN
    logic           xfer;
    logic [WIDTH:0] beat_mag;
    logic [AW-1:0]  beat_idx;
    logic [WIDTH:0] cand_mag;
    logic [AW-1:0]  cand_idx;
    logic [WIDTH:0] run_mag_p1;
    logic [AW-1:0]  run_idx_p1;
    logic [WIDTH:0] peak_mag_p1;
    logic [AW-1:0]  peak_idx_p1;
    logic           vld_p1;

    // |re|+|im| with one growth bit, so the most negative input still fits exactly.
    function automatic logic [WIDTH:0] l1_mag(input sample_t re, input sample_t im);
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        a = re[WIDTH-1] ? unsigned'(-re) : unsigned'(re);
        b = im[WIDTH-1] ? unsigned'(-im) : unsigned'(im);
        return {1'b0, a} + {1'b0, b};
    endfunction

    assign xfer = vld_p0 && bus.out_ready;

    // Strict comparisons keep the earlier (lower) bin on ties, both within and across beats.
    always_comb begin
        beat_mag = '0;
        beat_idx = base_p0;
        for (int k = 0; k < LANES; k++) begin
            if (l1_mag($signed(re_p0[k*WIDTH +: WIDTH]), $signed(im_p0[k*WIDTH +: WIDTH])) > beat_mag) begin
                beat_mag = l1_mag($signed(re_p0[k*WIDTH +: WIDTH]), $signed(im_p0[k*WIDTH +: WIDTH]));
                beat_idx = base_p0 + AW'(k);
            end
        end
        cand_mag = run_mag_p1;
        cand_idx = run_idx_p1;
        if (base_p0 == '0 || beat_mag > run_mag_p1) begin
            cand_mag = beat_mag;
            cand_idx = beat_idx;
        end
    end

    // Peak stage p1: running maximum over transferred beats, published after out_last
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_mag_p1  <= '0;
            run_idx_p1  <= '0;
            peak_mag_p1 <= '0;
            peak_idx_p1 <= '0;
            vld_p1      <= 1'b0;
        end else begin
            vld_p1 <= xfer && last_p0;
            if (xfer) begin
                run_mag_p1 <= cand_mag;
                run_idx_p1 <= cand_idx;
                if (last_p0) begin
                    peak_mag_p1 <= cand_mag;
                    peak_idx_p1 <= cand_idx;
                end
            end
        end
    end

    assign bus.peak_index = peak_idx_p1;
    assign bus.peak_mag   = peak_mag_p1;
    assign bus.peak_valid = vld_p1;
`endif
endmodule
